// File: rtl/wb_write_arbiter.sv
// Write-back arbiter: merges ALU results and buffered load returns onto
// the register file's single write port, preserving per-register order.
module wb_write_arbiter #(
   parameter int N     = 32,
   parameter int S     = 32,
   parameter int DEPTH = 2
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     alu_valid,
   input  logic [$clog2(S)-1:0]     alu_rd,
   input  logic [N-1:0]             alu_data,
   output logic                     alu_ready,
   input  logic                     mem_valid,
   input  logic [$clog2(S)-1:0]     mem_rd,
   input  logic [N-1:0]             mem_data,
   output logic                     mem_ready,
   output logic [$clog2(S)-1:0]     A3,
   output logic [N-1:0]             WD3,
   output logic                     WE3,
   output logic [S-1:0]             pending,
   output logic [$clog2(DEPTH):0]   fifo_count
);

   localparam int M  = $clog2(S);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [M-1:0]  fifo_rd   [DEPTH];
   logic [N-1:0]  fifo_data [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [CW-1:0] count;
   logic [DEPTH-1:0] occ;

   logic full;
   logic nonempty;
   logic alu_nz;
   logic push;
   logic pop;
   logic alu_wr;

   assign full       = (count == CW'(DEPTH));
   assign nonempty   = (count != '0);
   assign alu_nz     = (alu_rd != '0);
   assign mem_ready  = !full;
   assign push       = mem_valid && !full && (mem_rd != '0);
   assign fifo_count = count;

   // An entry slot is live when its distance from the head is below count.
   for (genvar i = 0; i < DEPTH; i++) begin : g_occ
      logic [AW-1:0] offs;
      assign offs   = AW'(i) - rd_ptr;
      assign occ[i] = ({1'b0, offs} < count);
   end

   always_comb begin
      pending = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (occ[i]) pending[fifo_rd[i]] = 1'b1;
      end
   end

   always_comb begin
      alu_ready = 1'b0;
      alu_wr    = 1'b0;
      pop       = 1'b0;
      if (full) begin
         pop = 1'b1;
      end else if (alu_valid && alu_nz && pending[alu_rd]) begin
         pop = nonempty;
      end else if (alu_valid && alu_nz) begin
         alu_ready = 1'b1;
         alu_wr    = 1'b1;
      end else if (alu_valid) begin
         alu_ready = 1'b1;
         pop       = nonempty;
      end else begin
         pop = nonempty;
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         fifo_rd[wr_ptr]   <= mem_rd;
         fifo_data[wr_ptr] <= mem_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         A3     <= '0;
         WD3    <= '0;
         WE3    <= 1'b0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         count <= count + CW'(push) - CW'(pop);
         if (pop) begin
            A3  <= fifo_rd[rd_ptr];
            WD3 <= fifo_data[rd_ptr];
            WE3 <= 1'b1;
         end else if (alu_wr) begin
            A3  <= alu_rd;
            WD3 <= alu_data;
            WE3 <= 1'b1;
         end else begin
            WE3 <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_wb_write_arbiter.sv
// Bench for wb_write_arbiter: directed vector table, then randomized
// traffic checked against a queue-based model of the write-back rules.
module tb_wb_write_arbiter;

   localparam int DEPTH = 2;

   logic        clk = 1'b0;
   logic        rst;
   logic        alu_valid;
   logic [4:0]  alu_rd;
   logic [31:0] alu_data;
   logic        alu_ready;
   logic        mem_valid;
   logic [4:0]  mem_rd;
   logic [31:0] mem_data;
   logic        mem_ready;
   logic [4:0]  A3;
   logic [31:0] WD3;
   logic        WE3;
   logic [31:0] pending;
   logic [1:0]  fifo_count;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   wb_write_arbiter #(.N(32), .S(32), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst),
      .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
      .alu_ready(alu_ready),
      .mem_valid(mem_valid), .mem_rd(mem_rd), .mem_data(mem_data),
      .mem_ready(mem_ready),
      .A3(A3), .WD3(WD3), .WE3(WE3),
      .pending(pending), .fifo_count(fifo_count)
   );

   typedef struct {
      logic        rst, av;
      logic [4:0]  ard;
      logic [31:0] adat;
      logic        mv;
      logic [4:0]  mrd;
      logic [31:0] mdat;
      logic        ar, mr, we;
      logic [4:0]  a3;
      logic [31:0] wd;
      logic [1:0]  cnt;
      logic [31:0] pend;
   } vec_t;

   typedef struct {
      logic [4:0]  rd;
      logic [31:0] dat;
   } ent_t;

   vec_t tbl[26];
   ent_t q[$];
   logic        m_we;
   logic [4:0]  m_a3;
   logic [31:0] m_wd;
   logic        e_ar, e_mr;
   logic [31:0] e_pend;

   function automatic vec_t v(
      logic r, logic av, logic [4:0] ard, logic [31:0] adat,
      logic mv, logic [4:0] mrd, logic [31:0] mdat,
      logic ar, logic mr, logic we, logic [4:0] a3, logic [31:0] wd,
      logic [1:0] cnt, logic [31:0] pend);
      vec_t t;
      t.rst = r; t.av = av; t.ard = ard; t.adat = adat;
      t.mv = mv; t.mrd = mrd; t.mdat = mdat;
      t.ar = ar; t.mr = mr; t.we = we; t.a3 = a3; t.wd = wd;
      t.cnt = cnt; t.pend = pend;
      return t;
   endfunction

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic check_all(input string tag, input logic ar,
      input logic mr, input logic we, input logic [4:0] a3,
      input logic [31:0] wd, input logic [1:0] cnt,
      input logic [31:0] pend);
      chk({tag, " alu_ready"}, 64'(alu_ready), 64'(ar));
      chk({tag, " mem_ready"}, 64'(mem_ready), 64'(mr));
      chk({tag, " WE3"}, 64'(WE3), 64'(we));
      chk({tag, " A3"}, 64'(A3), 64'(a3));
      chk({tag, " WD3"}, 64'(WD3), 64'(wd));
      chk({tag, " fifo_count"}, 64'(fifo_count), 64'(cnt));
      chk({tag, " pending"}, 64'(pending), 64'(pend));
   endtask

   function automatic logic [31:0] model_pend();
      logic [31:0] p = '0;
      foreach (q[i]) p[q[i].rd] = 1'b1;
      return p;
   endfunction

   initial begin
      tbl[0]  = v(0,0, 0,0,          0, 0,0,    0,1,0, 0,0,          0,0);
      tbl[1]  = v(0,1, 5,32'hDEADBEEF,0,0,0,    1,1,0, 0,0,          0,0);
      tbl[2]  = v(0,0, 0,0,          0, 0,0,    0,1,1, 5,32'hDEADBEEF,0,0);
      tbl[3]  = v(0,0, 0,0,          0, 0,0,    0,1,0, 5,32'hDEADBEEF,0,0);
      tbl[4]  = v(0,0, 0,0,          1, 7,32'h11,0,1,0,5,32'hDEADBEEF,0,0);
      tbl[5]  = v(0,0, 0,0,          0, 0,0,    0,1,0, 5,32'hDEADBEEF,1,32'h80);
      tbl[6]  = v(0,0, 0,0,          0, 0,0,    0,1,1, 7,32'h11,     0,0);
      tbl[7]  = v(0,1,10,32'hA0,     1, 3,32'h33,1,1,0,7,32'h11,     0,0);
      tbl[8]  = v(0,1,11,32'hB1,     1, 4,32'h44,1,1,1,10,32'hA0,    1,32'h8);
      tbl[9]  = v(0,1, 9,32'h99,     0, 0,0,    0,0,1,11,32'hB1,     2,32'h18);
      tbl[10] = v(0,1, 9,32'h99,     0, 0,0,    1,1,1, 3,32'h33,     1,32'h10);
      tbl[11] = v(0,0, 0,0,          0, 0,0,    0,1,1, 9,32'h99,     1,32'h10);
      tbl[12] = v(0,0, 0,0,          0, 0,0,    0,1,1, 4,32'h44,     0,0);
      tbl[13] = v(0,0, 0,0,          1, 6,32'hF6,0,1,0,4,32'h44,     0,0);
      tbl[14] = v(0,1, 6,32'hAA,     0, 0,0,    0,1,0, 4,32'h44,     1,32'h40);
      tbl[15] = v(0,1, 6,32'hAA,     0, 0,0,    1,1,1, 6,32'hF6,     0,0);
      tbl[16] = v(0,0, 0,0,          0, 0,0,    0,1,1, 6,32'hAA,     0,0);
      tbl[17] = v(0,1, 0,32'h55,     1, 0,32'h66,1,1,0,6,32'hAA,     0,0);
      tbl[18] = v(0,0, 0,0,          0, 0,0,    0,1,0, 6,32'hAA,     0,0);
      tbl[19] = v(0,0, 0,0,          0, 0,0,    0,1,0, 6,32'hAA,     0,0);
      tbl[20] = v(0,1,13,32'hD,      1,12,32'hC,1,1,0,6,32'hAA,      0,0);
      tbl[21] = v(0,1,15,32'hF,      1,14,32'hE,1,1,1,13,32'hD,      1,32'h1000);
      tbl[22] = v(1,0, 0,0,          0, 0,0,    0,0,1,15,32'hF,      2,32'h5000);
      tbl[23] = v(0,0, 0,0,          0, 0,0,    0,1,0, 0,0,          0,0);
      tbl[24] = v(0,0, 0,0,          0, 0,0,    0,1,0, 0,0,          0,0);
      tbl[25] = v(0,0, 0,0,          0, 0,0,    0,1,0, 0,0,          0,0);

      rst = 1'b1;
      alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
      mem_valid = 1'b0; mem_rd = '0; mem_data = '0;
      repeat (2) @(posedge clk);

      for (int i = 0; i < 26; i++) begin
         #1;
         rst = tbl[i].rst;
         alu_valid = tbl[i].av; alu_rd = tbl[i].ard; alu_data = tbl[i].adat;
         mem_valid = tbl[i].mv; mem_rd = tbl[i].mrd; mem_data = tbl[i].mdat;
         @(negedge clk);
         check_all($sformatf("vec%0d", i), tbl[i].ar, tbl[i].mr,
                   tbl[i].we, tbl[i].a3, tbl[i].wd, tbl[i].cnt,
                   tbl[i].pend);
         @(posedge clk);
      end

      q.delete();
      m_we = 1'b0; m_a3 = '0; m_wd = '0;
      e_ar = 1'b0; e_mr = 1'b1;
      for (int n = 0; n < 3000; n++) begin
         #1;
         if (rst || !(alu_valid && !e_ar)) begin
            alu_valid = ($urandom_range(0, 9) < 6);
            alu_rd    = 5'($urandom_range(0, 7));
            alu_data  = $urandom;
         end
         if (rst || !(mem_valid && !e_mr)) begin
            mem_valid = ($urandom_range(0, 9) < 6);
            mem_rd    = 5'($urandom_range(0, 7));
            mem_data  = $urandom;
         end
         rst = ($urandom_range(0, 99) == 0);
         e_pend = model_pend();
         e_mr = (q.size() < DEPTH);
         e_ar = alu_valid && e_mr &&
                !(alu_rd != 0 && e_pend[alu_rd]);
         @(negedge clk);
         check_all($sformatf("rnd%0d", n), e_ar, e_mr, m_we, m_a3, m_wd,
                   2'(q.size()), e_pend);
         @(posedge clk);
         if (rst) begin
            q.delete();
            m_we = 1'b0; m_a3 = '0; m_wd = '0;
         end else begin
            ent_t e;
            if (e_ar && alu_rd != 0) begin
               m_we = 1'b1; m_a3 = alu_rd; m_wd = alu_data;
            end else if (q.size() > 0) begin
               e = q.pop_front();
               m_we = 1'b1; m_a3 = e.rd; m_wd = e.dat;
            end else begin
               m_we = 1'b0;
            end
            if (mem_valid && e_mr && mem_rd != 0) begin
               e.rd = mem_rd; e.dat = mem_data;
               q.push_back(e);
            end
         end
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
